// File: rtl/clk_rst_pkg.sv
// Shared types and constants for the clk_rst clock-source switching logic.
package clk_rst_pkg;

    localparam int SRC_W   = 2;
    localparam int NUM_SRC = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        SWITCH   = 3'd2,
        SETTLE   = 3'd3,
        DONE     = 3'd4,
        FALLBACK = 3'd5
    } state_t;

endpackage

// File: rtl/sync_nff.sv
// N-stage flop synchronizer for a single asynchronous level signal.
module sync_nff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= '0;
        else        ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/clk_src_switch_ctrl.sv
// Sequences the select of the 4-source glitch-less clock mux: confirms target
// readiness, holds a settle window, and falls back to source 0 on loss of ready.
module clk_src_switch_ctrl
    import clk_rst_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RDY_TIMEOUT = 1024,
    parameter int SETTLE_CYC  = 16,
    parameter int FAIL_CYC    = 8,
    parameter int RST_SRC     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [SRC_W-1:0] req_src,
    output logic             req_ready,
    input  logic [NUM_SRC-1:0] src_rdy,
    input  logic             fallback_en,
    input  logic             fail_clr,
    output logic [SRC_W-1:0] sel,
    output logic [SRC_W-1:0] cur_src,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic             fail_flag
);

    localparam int MAX_AB = (RDY_TIMEOUT > SETTLE_CYC) ? RDY_TIMEOUT : SETTLE_CYC;
    localparam int MAXC   = (MAX_AB > FAIL_CYC) ? MAX_AB : FAIL_CYC;
    localparam int CW     = $clog2(MAXC + 1);

    logic [NUM_SRC-1:0] rdy_s;
    state_t             state;
    logic [SRC_W-1:0]   tgt;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      fcnt;
    logic               mon_act;
    logic               cur_low;
    logic               fail_det;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_sync
        sync_nff #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (src_rdy[gi]),
            .q     (rdy_s[gi])
        );
    end

    // Fail monitor watches the committed source only while nothing else is in flight.
    assign mon_act  = (state == IDLE) && fallback_en && (cur_src != '0);
    assign cur_low  = ~rdy_s[cur_src];
    assign fail_det = mon_act && cur_low && (fcnt == CW'(FAIL_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tgt         <= SRC_W'(RST_SRC);
            cnt         <= '0;
            fcnt        <= '0;
            sel         <= SRC_W'(RST_SRC);
            cur_src     <= SRC_W'(RST_SRC);
            req_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            fail_flag   <= 1'b0;
        end else begin
            done        <= 1'b0;
            timeout_err <= 1'b0;

            if (fail_det)      fail_flag <= 1'b1;
            else if (fail_clr) fail_flag <= 1'b0;

            if (mon_act && cur_low && !fail_det)
                fcnt <= (fcnt == '1) ? fcnt : fcnt + 1'b1;
            else
                fcnt <= '0;

            case (state)
                IDLE: begin
                    if (fail_det) begin
                        tgt       <= '0;
                        state     <= FALLBACK;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                    end else if (req_valid) begin
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        if (req_src == cur_src) begin
                            state <= DONE;
                        end else begin
                            tgt   <= req_src;
                            cnt   <= '0;
                            state <= WAIT_RDY;
                        end
                    end
                end
                WAIT_RDY: begin
                    if (rdy_s[tgt]) begin
                        state <= SWITCH;
                    end else if (cnt == CW'(RDY_TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                        busy        <= 1'b0;
                        req_ready   <= 1'b1;
                    end else begin
                        cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
                    end
                end
                SWITCH: begin
                    sel   <= tgt;
                    cnt   <= '0;
                    state <= SETTLE;
                end
                FALLBACK: begin
                    sel   <= '0;
                    cnt   <= '0;
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == CW'(SETTLE_CYC - 1)) begin
                        cur_src <= sel;
                        state   <= DONE;
                    end else begin
                        cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
                    end
                end
                DONE: begin
                    done      <= 1'b1;
                    state     <= IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_src_switch_ctrl.sv
// Directed bench for clk_src_switch_ctrl with default parameters.
module tb_clk_src_switch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [1:0] req_src;
    logic       req_ready;
    logic [3:0] src_rdy;
    logic       fallback_en;
    logic       fail_clr;
    logic [1:0] sel;
    logic [1:0] cur_src;
    logic       busy;
    logic       done;
    logic       timeout_err;
    logic       fail_flag;

    int total = 0;
    int bad   = 0;

    clk_src_switch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_src     (req_src),
        .req_ready   (req_ready),
        .src_rdy     (src_rdy),
        .fallback_en (fallback_en),
        .fail_clr    (fail_clr),
        .sel         (sel),
        .cur_src     (cur_src),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .fail_flag   (fail_flag)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue a request to a ready source; done appears 19 edges after the accept edge.
    task automatic do_switch(input logic [1:0] src, input string tag);
        req_valid = 1'b1;
        req_src   = src;
        step(1);
        req_valid = 1'b0;
        step(19);
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_cur"}, 32'(cur_src), 32'(src));
        step(1);
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_src     = 2'd0;
        src_rdy     = 4'b1111;
        fallback_en = 1'b0;
        fail_clr    = 1'b0;
        step(3);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_cur", 32'(cur_src), 0);
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_tmo", 32'(timeout_err), 0);
        chk("rst_fail", 32'(fail_flag), 0);
        rst_n = 1'b1;
        step(4);
        chk("idle_done", 32'(done), 0);

        // Switch to source 2 with ready already synchronized high
        req_valid = 1'b1;
        req_src   = 2'd2;
        step(1);
        req_valid = 1'b0;
        chk("sw2_ready_low", 32'(req_ready), 0);
        chk("sw2_busy", 32'(busy), 1);
        step(1);
        chk("sw2_sel_hold", 32'(sel), 0);
        step(1);
        chk("sw2_sel", 32'(sel), 2);
        step(16);
        chk("sw2_cur", 32'(cur_src), 2);
        chk("sw2_done_early", 32'(done), 0);
        step(1);
        chk("sw2_done", 32'(done), 1);
        chk("sw2_ready", 32'(req_ready), 1);
        step(1);
        chk("sw2_done_pulse", 32'(done), 0);

        // Same-source request completes without touching sel
        req_valid = 1'b1;
        req_src   = 2'd2;
        step(1);
        req_valid = 1'b0;
        chk("same_busy", 32'(busy), 1);
        step(1);
        chk("same_done", 32'(done), 1);
        chk("same_sel", 32'(sel), 2);
        step(1);

        // Timeout on source 3 that never becomes ready
        src_rdy[3] = 1'b0;
        step(4);
        req_valid = 1'b1;
        req_src   = 2'd3;
        step(1);
        req_valid = 1'b0;
        step(1023);
        chk("tmo_early", 32'(timeout_err), 0);
        chk("tmo_busy", 32'(busy), 1);
        step(1);
        chk("tmo_pulse", 32'(timeout_err), 1);
        chk("tmo_sel", 32'(sel), 2);
        chk("tmo_cur", 32'(cur_src), 2);
        chk("tmo_ready", 32'(req_ready), 1);
        step(1);
        chk("tmo_clear", 32'(timeout_err), 0);
        src_rdy[3] = 1'b1;
        step(4);

        // Move to source 1, then a short ready glitch must not trigger fallback
        do_switch(2'd1, "sw1");
        fallback_en = 1'b1;
        src_rdy[1]  = 1'b0;
        step(7);
        src_rdy[1]  = 1'b1;
        step(12);
        chk("glitch_fail", 32'(fail_flag), 0);
        chk("glitch_sel", 32'(sel), 1);
        chk("glitch_busy", 32'(busy), 0);

        // Sustained loss of ready: detection on the 10th edge after the drop
        src_rdy[1] = 1'b0;
        step(9);
        chk("fb_pre", 32'(fail_flag), 0);
        step(1);
        chk("fb_flag", 32'(fail_flag), 1);
        chk("fb_ready", 32'(req_ready), 0);
        chk("fb_sel_hold", 32'(sel), 1);
        step(1);
        chk("fb_sel", 32'(sel), 0);
        step(17);
        chk("fb_done", 32'(done), 1);
        chk("fb_cur", 32'(cur_src), 0);
        fail_clr = 1'b1;
        step(1);
        fail_clr = 1'b0;
        chk("fb_clr", 32'(fail_flag), 0);

        // Fallback coincident with a request and a fail_clr pulse
        src_rdy[1] = 1'b1;
        step(4);
        do_switch(2'd1, "sw1b");
        src_rdy[1] = 1'b0;
        step(9);
        req_valid = 1'b1;
        req_src   = 2'd2;
        fail_clr  = 1'b1;
        step(1);
        fail_clr = 1'b0;
        chk("coin_flag", 32'(fail_flag), 1);
        chk("coin_ready", 32'(req_ready), 0);
        chk("coin_busy", 32'(busy), 1);
        step(1);
        chk("coin_sel", 32'(sel), 0);
        step(17);
        chk("coin_done", 32'(done), 1);
        chk("coin_cur", 32'(cur_src), 0);
        step(1);
        req_valid = 1'b0;
        step(19);
        chk("coin_re_done", 32'(done), 1);
        chk("coin_re_cur", 32'(cur_src), 2);
        chk("coin_re_sel", 32'(sel), 2);
        step(1);
        src_rdy[1] = 1'b1;
        step(4);

        // Asynchronous reset in the middle of the settle window
        req_valid = 1'b1;
        req_src   = 2'd3;
        step(1);
        req_valid = 1'b0;
        step(2);
        chk("mid_sel3", 32'(sel), 3);
        step(5);
        rst_n = 1'b0;
        #2;
        chk("arst_sel", 32'(sel), 0);
        chk("arst_cur", 32'(cur_src), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready", 32'(req_ready), 1);
        step(2);
        rst_n = 1'b1;
        step(4);
        do_switch(2'd1, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
